// File: rtl/id_stage.sv
// RV32I decode stage: register file, immediate generator, main decoder,
// load-use hazard detector and the ID/EX pipeline register.
module id_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [31:0]       id_instr,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [3:0]        ex_alu_op,
  output logic              ex_alu_src_imm,
  output logic              ex_alu_src_pc,
  output logic              ex_reg_we,
  output logic              ex_mem_re,
  output logic              ex_mem_we,
  output logic              ex_branch,
  output logic              ex_jal,
  output logic              ex_jalr,
  output logic [1:0]        ex_wb_sel,
  output logic              ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [REG_AW-1:0] REG_ZERO  = {REG_AW{1'b0}};
  localparam logic [XLEN-1:0]   DATA_ZERO = {XLEN{1'b0}};
  localparam int                NREGS     = 1 << REG_AW;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic [3:0]        alu_op;
    logic              alu_src_imm;
    logic              alu_src_pc;
    logic              reg_we;
    logic              mem_re;
    logic              mem_we;
    logic              branch;
    logic              jal;
    logic              jalr;
    logic [1:0]        wb_sel;
    logic              illegal;
  } idex_t;

  // Immediate extraction; the signed cast sign-extends to XLEN.
  function automatic logic [XLEN-1:0] imm_i(input logic [31:0] i);
    return XLEN'($signed(i[31:20]));
  endfunction

  function automatic logic [XLEN-1:0] imm_s(input logic [31:0] i);
    return XLEN'($signed({i[31:25], i[11:7]}));
  endfunction

  function automatic logic [XLEN-1:0] imm_b(input logic [31:0] i);
    return XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
  endfunction

  function automatic logic [XLEN-1:0] imm_u(input logic [31:0] i);
    return XLEN'($signed({i[31:12], 12'h000}));
  endfunction

  function automatic logic [XLEN-1:0] imm_j(input logic [31:0] i);
    return XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
  endfunction

  // ALU operation for OP/OP-IMM; alt selects SUB/SRA.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic [6:0]        opcode_s;
  logic [2:0]        f3_s;
  logic [6:0]        f7_s;
  logic [REG_AW-1:0] rd_f_s;
  logic [REG_AW-1:0] rs1_f_s;
  logic [REG_AW-1:0] rs2_f_s;
  logic              bad_s;
  idex_t             dec_s;
  idex_t             bundle_s;
  idex_t             ex_r;
  logic [XLEN-1:0]   rs1_data_s;
  logic [XLEN-1:0]   rs2_data_s;
  logic              load_use_s;
  logic [XLEN-1:0]   rf_r [NREGS];

  assign opcode_s = id_instr[6:0];
  assign f3_s     = id_instr[14:12];
  assign f7_s     = id_instr[31:25];
  assign rd_f_s   = id_instr[11:7];
  assign rs1_f_s  = id_instr[19:15];
  assign rs2_f_s  = id_instr[24:20];

  // Main decoder: fields absent from the format stay 0; illegal encodings keep only valid/pc/illegal.
  always_comb begin
    dec_s = '0;
    bad_s = 1'b0;
    if (id_instr == 32'h0000_0000) begin
      dec_s = '0;
    end else begin
      dec_s.valid = 1'b1;
      dec_s.pc    = id_pc;
      case (opcode_s)
        OPC_LUI: begin
          dec_s.rd          = rd_f_s;
          dec_s.imm         = imm_u(id_instr);
          dec_s.alu_op      = ALU_PASSB;
          dec_s.alu_src_imm = 1'b1;
          dec_s.reg_we      = 1'b1;
        end
        OPC_AUIPC: begin
          dec_s.rd          = rd_f_s;
          dec_s.imm         = imm_u(id_instr);
          dec_s.alu_op      = ALU_ADD;
          dec_s.alu_src_imm = 1'b1;
          dec_s.alu_src_pc  = 1'b1;
          dec_s.reg_we      = 1'b1;
        end
        OPC_JAL: begin
          dec_s.rd          = rd_f_s;
          dec_s.imm         = imm_j(id_instr);
          dec_s.alu_op      = ALU_ADD;
          dec_s.alu_src_imm = 1'b1;
          dec_s.alu_src_pc  = 1'b1;
          dec_s.jal         = 1'b1;
          dec_s.reg_we      = 1'b1;
          dec_s.wb_sel      = WB_PC4;
        end
        OPC_JALR: begin
          if (f3_s == 3'b000) begin
            dec_s.rd          = rd_f_s;
            dec_s.rs1         = rs1_f_s;
            dec_s.funct3      = f3_s;
            dec_s.imm         = imm_i(id_instr);
            dec_s.alu_op      = ALU_ADD;
            dec_s.alu_src_imm = 1'b1;
            dec_s.alu_src_pc  = 1'b1;
            dec_s.jalr        = 1'b1;
            dec_s.reg_we      = 1'b1;
            dec_s.wb_sel      = WB_PC4;
          end else begin
            bad_s = 1'b1;
          end
        end
        OPC_BRANCH: begin
          if ((f3_s != 3'b010) && (f3_s != 3'b011)) begin
            dec_s.rs1    = rs1_f_s;
            dec_s.rs2    = rs2_f_s;
            dec_s.funct3 = f3_s;
            dec_s.imm    = imm_b(id_instr);
            dec_s.alu_op = ALU_SUB;
            dec_s.branch = 1'b1;
          end else begin
            bad_s = 1'b1;
          end
        end
        OPC_LOAD: begin
          if (f3_s inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
            dec_s.rd          = rd_f_s;
            dec_s.rs1         = rs1_f_s;
            dec_s.funct3      = f3_s;
            dec_s.imm         = imm_i(id_instr);
            dec_s.alu_op      = ALU_ADD;
            dec_s.alu_src_imm = 1'b1;
            dec_s.mem_re      = 1'b1;
            dec_s.reg_we      = 1'b1;
            dec_s.wb_sel      = WB_MEM;
          end else begin
            bad_s = 1'b1;
          end
        end
        OPC_STORE: begin
          if (f3_s inside {3'b000, 3'b001, 3'b010}) begin
            dec_s.rs1         = rs1_f_s;
            dec_s.rs2         = rs2_f_s;
            dec_s.funct3      = f3_s;
            dec_s.imm         = imm_s(id_instr);
            dec_s.alu_op      = ALU_ADD;
            dec_s.alu_src_imm = 1'b1;
            dec_s.mem_we      = 1'b1;
          end else begin
            bad_s = 1'b1;
          end
        end
        OPC_OPIMM: begin
          case (f3_s)
            3'b001:  bad_s = (f7_s != 7'b0000000);
            3'b101:  bad_s = (f7_s != 7'b0000000) && (f7_s != 7'b0100000);
            default: bad_s = 1'b0;
          endcase
          dec_s.rd          = rd_f_s;
          dec_s.rs1         = rs1_f_s;
          dec_s.funct3      = f3_s;
          dec_s.imm         = imm_i(id_instr);
          dec_s.alu_op      = alu_from_f3(f3_s, (f3_s == 3'b101) && f7_s[5]);
          dec_s.alu_src_imm = 1'b1;
          dec_s.reg_we      = 1'b1;
        end
        OPC_OP: begin
          bad_s = !((f7_s == 7'b0000000) ||
                    ((f7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101))));
          dec_s.rd     = rd_f_s;
          dec_s.rs1    = rs1_f_s;
          dec_s.rs2    = rs2_f_s;
          dec_s.funct3 = f3_s;
          dec_s.alu_op = alu_from_f3(f3_s, f7_s[5]);
          dec_s.reg_we = 1'b1;
        end
        OPC_FENCE: begin
          bad_s = (f3_s != 3'b000);
        end
        default: begin
          bad_s = 1'b1;
        end
      endcase
      if (bad_s) begin
        dec_s         = '0;
        dec_s.valid   = 1'b1;
        dec_s.pc      = id_pc;
        dec_s.illegal = 1'b1;
      end else begin
        dec_s.reg_we = dec_s.reg_we & (dec_s.rd != REG_ZERO);
      end
    end
  end

  // Register file read ports: x0 reads 0, a same-cycle writeback is bypassed.
  always_comb begin
    if (dec_s.rs1 == REG_ZERO) begin
      rs1_data_s = DATA_ZERO;
    end else if (wb_we && (wb_rd == dec_s.rs1)) begin
      rs1_data_s = wb_data;
    end else begin
      rs1_data_s = rf_r[dec_s.rs1];
    end
    if (dec_s.rs2 == REG_ZERO) begin
      rs2_data_s = DATA_ZERO;
    end else if (wb_we && (wb_rd == dec_s.rs2)) begin
      rs2_data_s = wb_data;
    end else begin
      rs2_data_s = rf_r[dec_s.rs2];
    end
  end

  // Merge operands into the decoded bundle.
  always_comb begin
    bundle_s          = dec_s;
    bundle_s.rs1_data = rs1_data_s;
    bundle_s.rs2_data = rs2_data_s;
  end

  // Load-use hazard: unused source fields decode to 0 and never match a non-zero rd.
  always_comb begin
    if (ex_r.valid && ex_r.mem_re && (ex_r.rd != REG_ZERO)) begin
      load_use_s = (dec_s.rs1 == ex_r.rd) || (dec_s.rs2 == ex_r.rd);
    end else begin
      load_use_s = 1'b0;
    end
  end

  assign load_use_stall = load_use_s;

  // Register file write port; reset clears every entry and drops a concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_r[i] <= DATA_ZERO;
      end
    end else if (wb_we && (wb_rd != REG_ZERO)) begin
      rf_r[wb_rd] <= wb_data;
    end
  end

  // ID/EX register: reset, flush, hold, hazard bubble, then load, in that priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r <= '0;
    end else if (flush) begin
      ex_r <= '0;
    end else if (stall) begin
      ex_r <= ex_r;
    end else if (load_use_s) begin
      ex_r <= '0;
    end else begin
      ex_r <= bundle_s;
    end
  end

  assign ex_valid       = ex_r.valid;
  assign ex_pc          = ex_r.pc;
  assign ex_rs1_data    = ex_r.rs1_data;
  assign ex_rs2_data    = ex_r.rs2_data;
  assign ex_imm         = ex_r.imm;
  assign ex_rs1         = ex_r.rs1;
  assign ex_rs2         = ex_r.rs2;
  assign ex_rd          = ex_r.rd;
  assign ex_funct3      = ex_r.funct3;
  assign ex_alu_op      = ex_r.alu_op;
  assign ex_alu_src_imm = ex_r.alu_src_imm;
  assign ex_alu_src_pc  = ex_r.alu_src_pc;
  assign ex_reg_we      = ex_r.reg_we;
  assign ex_mem_re      = ex_r.mem_re;
  assign ex_mem_we      = ex_r.mem_we;
  assign ex_branch      = ex_r.branch;
  assign ex_jal         = ex_r.jal;
  assign ex_jalr        = ex_r.jalr;
  assign ex_wb_sel      = ex_r.wb_sel;
  assign ex_illegal     = ex_r.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed cases with literal expectations,
// then randomized traffic checked against a behavioural model every cycle.
module tb_id_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic [1:0]  wb_sel;
    logic        illegal;
  } bundle_t;

  // ALU codes for funct3 0..7 without the alternate bit: ADD SLL SLT SLTU XOR SRL OR AND
  localparam logic [31:0] ALU_TBL = {4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd0};

  logic        clk = 1'b0;
  logic        rst, stall, flush, wb_we;
  logic [31:0] id_pc, id_instr, wb_data;
  logic [4:0]  wb_rd;
  logic        load_use_stall, ex_valid, ex_alu_src_imm, ex_alu_src_pc, ex_reg_we;
  logic        ex_mem_re, ex_mem_we, ex_branch, ex_jal, ex_jalr, ex_illegal;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_alu_op;
  logic [1:0]  ex_wb_sel;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic cmp_en = 1'b0;

  logic [31:0] regs_m [32];
  bundle_t     exp_ex;
  bundle_t     nxt_ex;
  logic        exp_lus;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_pc(id_pc), .id_instr(id_instr),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .load_use_stall(load_use_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm), .ex_alu_src_pc(ex_alu_src_pc),
    .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_wb_sel(ex_wb_sel), .ex_illegal(ex_illegal)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act !== expv) begin
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // Spec-level decode: classify by format, then fill fields the format carries.
  function automatic bundle_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                           output logic use1, output logic use2);
    bundle_t b;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    byte fmt;
    logic ok;
    b = '0; use1 = 1'b0; use2 = 1'b0;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    ok = 1'b0; fmt = "N";
    if (ins == 32'h0) return b;
    case (opc)
      7'h37: begin fmt = "U"; ok = 1'b1; b.alu_op = 4'd10; b.alu_src_imm = 1'b1; end
      7'h17: begin fmt = "U"; ok = 1'b1; b.alu_src_imm = 1'b1; b.alu_src_pc = 1'b1; end
      7'h6F: begin fmt = "J"; ok = 1'b1; b.alu_src_imm = 1'b1; b.alu_src_pc = 1'b1;
                   b.jal = 1'b1; b.wb_sel = 2'd2; end
      7'h67: begin fmt = "I"; ok = (f3 == 3'd0); b.alu_src_imm = 1'b1; b.alu_src_pc = 1'b1;
                   b.jalr = 1'b1; b.wb_sel = 2'd2; end
      7'h63: begin fmt = "B"; ok = (f3 != 3'd2) && (f3 != 3'd3); b.alu_op = 4'd1; b.branch = 1'b1; end
      7'h03: begin fmt = "I"; ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                   b.alu_src_imm = 1'b1; b.mem_re = 1'b1; b.wb_sel = 2'd1; end
      7'h23: begin fmt = "S"; ok = (f3 < 3'd3); b.alu_src_imm = 1'b1; b.mem_we = 1'b1; end
      7'h13: begin
        fmt = "I"; b.alu_src_imm = 1'b1;
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
        else ok = 1'b1;
        b.alu_op = ALU_TBL[f3*4 +: 4];
        if (f3 == 3'd5 && f7 == 7'h20) b.alu_op = 4'd7;
      end
      7'h33: begin
        fmt = "R";
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        b.alu_op = ALU_TBL[f3*4 +: 4];
        if (f7 == 7'h20 && f3 == 3'd0) b.alu_op = 4'd1;
        if (f7 == 7'h20 && f3 == 3'd5) b.alu_op = 4'd7;
      end
      7'h0F: begin fmt = "N"; ok = (f3 == 3'd0); end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      b = '0; b.valid = 1'b1; b.pc = pc; b.illegal = 1'b1;
      return b;
    end
    b.valid = 1'b1; b.pc = pc;
    if (fmt inside {"U", "J", "I", "R"}) begin
      b.rd = ins[11:7];
      b.reg_we = (ins[11:7] != 5'd0);
    end
    if (fmt inside {"I", "S", "B", "R"}) begin
      b.rs1 = ins[19:15]; b.funct3 = f3; use1 = 1'b1;
    end
    if (fmt inside {"S", "B", "R"}) begin
      b.rs2 = ins[24:20]; use2 = 1'b1;
    end
    case (fmt)
      "I": b.imm = {{20{ins[31]}}, ins[31:20]};
      "S": b.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      "B": b.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      "U": b.imm = {ins[31:12], 12'h000};
      "J": b.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: b.imm = 32'h0;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] rf_model(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (wb_we && wb_rd == idx) return wb_data;
    return regs_m[idx];
  endfunction

  // Present one cycle of inputs, check the combinational stall, compute the next ID/EX.
  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic st,
                       input logic fl, input logic rs, input logic we,
                       input logic [4:0] rd, input logic [31:0] wd);
    bundle_t d;
    logic u1, u2;
    @(negedge clk);
    #2;
    id_instr = ins; id_pc = pc; stall = st; flush = fl; rst = rs;
    wb_we = we; wb_rd = rd; wb_data = wd;
    #1;
    d = model_decode(ins, pc, u1, u2);
    d.rs1_data = rf_model(d.rs1);
    d.rs2_data = rf_model(d.rs2);
    exp_lus = exp_ex.valid && exp_ex.mem_re && (exp_ex.rd != 5'd0) &&
              ((u1 && ins[19:15] == exp_ex.rd) || (u2 && ins[24:20] == exp_ex.rd));
    if (cmp_en) chk("load_use_stall", {31'b0, load_use_stall}, {31'b0, exp_lus});
    if (rs || fl) nxt_ex = '0;
    else if (st) nxt_ex = exp_ex;
    else if (exp_lus) nxt_ex = '0;
    else nxt_ex = d;
  endtask

  // Clock edge: advance model state alongside the DUT.
  task automatic tick;
    @(posedge clk);
    exp_ex = nxt_ex;
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_m[i] = 32'h0;
    end else if (wb_we && wb_rd != 5'd0) begin
      regs_m[wb_rd] = wb_data;
    end
    #1;
  endtask

  // Compare process: whole ID/EX bundle against the model every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ex_valid", {31'b0, ex_valid}, {31'b0, exp_ex.valid});
      chk("ex_pc", ex_pc, exp_ex.pc);
      chk("ex_rs1_data", ex_rs1_data, exp_ex.rs1_data);
      chk("ex_rs2_data", ex_rs2_data, exp_ex.rs2_data);
      chk("ex_imm", ex_imm, exp_ex.imm);
      chk("ex_rs1", {27'b0, ex_rs1}, {27'b0, exp_ex.rs1});
      chk("ex_rs2", {27'b0, ex_rs2}, {27'b0, exp_ex.rs2});
      chk("ex_rd", {27'b0, ex_rd}, {27'b0, exp_ex.rd});
      chk("ex_funct3", {29'b0, ex_funct3}, {29'b0, exp_ex.funct3});
      chk("ex_alu_op", {28'b0, ex_alu_op}, {28'b0, exp_ex.alu_op});
      chk("ex_ctrl", {22'b0, ex_alu_src_imm, ex_alu_src_pc, ex_reg_we, ex_mem_re, ex_mem_we,
                      ex_branch, ex_jal, ex_jalr, ex_wb_sel},
                     {22'b0, exp_ex.alu_src_imm, exp_ex.alu_src_pc, exp_ex.reg_we, exp_ex.mem_re,
                      exp_ex.mem_we, exp_ex.branch, exp_ex.jal, exp_ex.jalr, exp_ex.wb_sel});
      chk("ex_illegal", {31'b0, ex_illegal}, {31'b0, exp_ex.illegal});
    end
  end

  function automatic logic [31:0] rand_instr;
    logic [4:0] rd, r1, r2;
    logic [2:0] f3;
    logic [6:0] f7;
    int k;
    rd = 5'($urandom_range(0, 7));
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    k = $urandom_range(0, 2);
    f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : 7'($urandom);
    case ($urandom_range(0, 13))
      0:  return {20'($urandom), rd, 7'h37};
      1:  return {20'($urandom), rd, 7'h17};
      2:  return {20'($urandom), rd, 7'h6F};
      3:  return {12'($urandom), r1, ($urandom_range(0, 3) == 0) ? f3 : 3'd0, rd, 7'h67};
      4:  return {7'($urandom), r2, r1, f3, 5'($urandom), 7'h63};
      5, 12, 13: return {12'($urandom), r1, ($urandom_range(0, 3) == 0) ? f3 : 3'd2, rd, 7'h03};
      6:  return {7'($urandom), r2, r1, 3'($urandom_range(0, 3)), 5'($urandom), 7'h23};
      7:  return {f7, 5'($urandom), r1, f3, rd, 7'h13};
      8:  return {f7, r2, r1, f3, rd, 7'h33};
      9:  return ($urandom_range(0, 1) == 0) ? 32'h0000_000F : 32'h0000_0073;
      10: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  localparam logic [31:0] I_ADDI_M1  = 32'hFFF00093; // ADDI x1,x0,-1
  localparam logic [31:0] I_ADD_433  = 32'h00318233; // ADD x4,x3,x3
  localparam logic [31:0] I_ADD_655  = 32'h00528333; // ADD x6,x5,x5
  localparam logic [31:0] I_LW_21    = 32'h0000A103; // LW x2,0(x1)
  localparam logic [31:0] I_ADD_520  = 32'h000102B3; // ADD x5,x2,x0
  localparam logic [31:0] I_ECALL    = 32'h00000073;
  localparam logic [31:0] I_ADDI_X0  = 32'h00500013; // ADDI x0,x0,5

  initial begin
    logic [31:0] cur_ins, cur_pc;
    logic st, fl, rs;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = 5'd0;
    wb_data = 32'h0; id_pc = 32'h0; id_instr = 32'h0;
    exp_ex = '0; nxt_ex = '0; exp_lus = 1'b0;
    for (int i = 0; i < 32; i++) regs_m[i] = 32'h0;

    // Reset for two cycles while a write to x5 is attempted.
    drive(I_ADDI_M1, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'h1);
    tick;
    cmp_en = 1'b1;
    drive(I_ADDI_M1, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'h1);
    tick;
    chk("reset ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("reset ex_imm", ex_imm, 32'h0);
    chk("reset ex_reg_we", {31'b0, ex_reg_we}, 32'h0);

    // x5 still reads 0 after the discarded write.
    drive(I_ADD_655, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick;
    chk("x5 after reset", ex_rs1_data, 32'h0);

    // ADDI x1,x0,-1
    drive(I_ADDI_M1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick;
    chk("addi valid", {31'b0, ex_valid}, 32'h1);
    chk("addi imm", ex_imm, 32'hFFFF_FFFF);
    chk("addi alu_op", {28'b0, ex_alu_op}, 32'h0);
    chk("addi src_imm", {31'b0, ex_alu_src_imm}, 32'h1);
    chk("addi rd", {27'b0, ex_rd}, 32'h1);
    chk("addi reg_we", {31'b0, ex_reg_we}, 32'h1);
    chk("model addi imm", exp_ex.imm, 32'hFFFF_FFFF);

    // Same-cycle writeback bypass on both operands.
    drive(I_ADD_433, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    tick;
    chk("bypass rs1", ex_rs1_data, 32'hDEAD_BEEF);
    chk("bypass rs2", ex_rs2_data, 32'hDEAD_BEEF);

    // Load-use: one bubble, then the dependent ADD enters.
    drive(I_LW_21, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick;
    chk("lw mem_re", {31'b0, ex_mem_re}, 32'h1);
    drive(I_ADD_520, 32'h404, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("lu asserted", {31'b0, load_use_stall}, 32'h1);
    chk("model lu asserted", {31'b0, exp_lus}, 32'h1);
    tick;
    chk("lu bubble", {31'b0, ex_valid}, 32'h0);
    drive(I_ADD_520, 32'h404, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("lu released", {31'b0, load_use_stall}, 32'h0);
    tick;
    chk("lu add valid", {31'b0, ex_valid}, 32'h1);
    chk("lu add rd", {27'b0, ex_rd}, 32'h5);
    chk("lu add pc", ex_pc, 32'h404);

    // Flush beats stall; stall alone holds for three cycles.
    drive(I_ADDI_M1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick;
    drive(I_ADDI_M1, 32'h204, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    tick;
    chk("flush+stall valid", {31'b0, ex_valid}, 32'h0);
    drive(I_ADDI_M1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick;
    for (int k = 0; k < 3; k++) begin
      drive(I_ADD_433, 32'h304 + 32'(4 * k), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      tick;
      chk("stall holds pc", ex_pc, 32'h300);
    end

    // ECALL is illegal; writes to x0 are suppressed.
    drive(I_ECALL, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick;
    chk("ecall illegal", {31'b0, ex_illegal}, 32'h1);
    chk("ecall reg_we", {31'b0, ex_reg_we}, 32'h0);
    chk("ecall valid", {31'b0, ex_valid}, 32'h1);
    chk("model ecall illegal", {31'b0, exp_ex.illegal}, 32'h1);
    drive(I_ADDI_X0, 32'h504, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick;
    chk("addi x0 reg_we", {31'b0, ex_reg_we}, 32'h0);
    chk("addi x0 valid", {31'b0, ex_valid}, 32'h1);

    // Randomized traffic; IF/ID holds its instruction while a load-use stall is raised.
    cur_pc = 32'h1000;
    cur_ins = rand_instr();
    for (int n = 0; n < 3000; n++) begin
      st = ($urandom_range(0, 9) == 0);
      fl = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 249) == 0);
      drive(cur_ins, cur_pc, st, fl, rs, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom);
      if (!(exp_lus && !rs && !fl)) begin
        cur_ins = rand_instr();
        cur_pc = cur_pc + 32'd4;
      end
      tick;
    end

    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
